gen2_cmd_tx: RTL and testbench

Reader-side Gen2 command serializer: builds a reader-to-tag command frame from command select and field inputs, appends CRC5 or CRC16 where the protocol requires it, and shifts the frame out one bit per bit strobe for the downstream PIE modulator. It is the transmit counterpart of the tag's command parser. Its bitstream is bit-exact with what the tag parser decodes, including CRC residues (CRC5 = 0, CRC16 = 0x1D0F), so the two are used together in loopback benches.

---
 rtl/gen2_pkg.sv | 53 +++++
 rtl/gen2_crc_gen.sv | 34 +++
 rtl/gen2_cmd_tx.sv | 146 ++++++++++++++
 tb/tb_gen2_cmd_tx.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen2_pkg.sv
// Shared Gen2 reader-command definitions: opcodes, frame geometry, CRC constants
// and the serializer state encoding.
package gen2_pkg;

    localparam logic [3:0] CMD_QUERYREP = 4'd0;
    localparam logic [3:0] CMD_ACK      = 4'd1;
    localparam logic [3:0] CMD_QUERY    = 4'd2;
    localparam logic [3:0] CMD_QUERYADJ = 4'd3;
    localparam logic [3:0] CMD_NACK     = 4'd5;
    localparam logic [3:0] CMD_REQRN    = 4'd6;
    localparam logic [3:0] CMD_READ     = 4'd7;

    localparam logic [4:0]  CRC5_PRESET   = 5'b01001;
    localparam logic [4:0]  CRC5_POLY     = 5'b01001;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    typedef enum logic [1:0] {CRC_NONE, CRC_5, CRC_16} crc_kind_t;

    typedef enum logic [2:0] {S_IDLE, S_BODY, S_CRC5, S_CRC16, S_FINISH} tx_state_t;

    function automatic logic cmd_valid(input logic [3:0] cmd);
        case (cmd)
            CMD_QUERYREP, CMD_ACK, CMD_QUERY, CMD_QUERYADJ,
            CMD_NACK, CMD_REQRN, CMD_READ: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Body length excludes any trailing CRC bits.
    function automatic logic [5:0] cmd_body_len(input logic [3:0] cmd);
        case (cmd)
            CMD_QUERYREP: return 6'd4;
            CMD_ACK:      return 6'd18;
            CMD_QUERY:    return 6'd17;
            CMD_QUERYADJ: return 6'd9;
            CMD_NACK:     return 6'd8;
            CMD_REQRN:    return 6'd24;
            CMD_READ:     return 6'd42;
            default:      return 6'd0;
        endcase
    endfunction

    function automatic crc_kind_t cmd_crc_kind(input logic [3:0] cmd);
        case (cmd)
            CMD_QUERY:           return CRC_5;
            CMD_REQRN, CMD_READ: return CRC_16;
            default:             return CRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gen2_crc_gen.sv
// Serial CRC5/CRC16 generator; both registers advance together on every enabled bit.
module gen2_crc_gen
    import gen2_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        preset,
    input  logic        enable,
    input  logic        din,
    output logic [4:0]  crc5,
    output logic [15:0] crc16,
    output logic [4:0]  crc5_next,
    output logic [15:0] crc16_next
);

    always_comb begin
        crc5_next  = {crc5[3:0], 1'b0} ^ ((din ^ crc5[4]) ? CRC5_POLY : 5'd0);
        crc16_next = {crc16[14:0], 1'b0} ^ ((din ^ crc16[15]) ? CRC16_POLY : 16'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc5  <= CRC5_PRESET;
            crc16 <= CRC16_PRESET;
        end else if (preset) begin
            crc5  <= CRC5_PRESET;
            crc16 <= CRC16_PRESET;
        end else if (enable) begin
            crc5  <= crc5_next;
            crc16 <= crc16_next;
        end
    end

endmodule

// File: rtl/gen2_cmd_tx.sv
// Gen2 reader command serializer: latches a command frame, appends its CRC and
// shifts it out MSB first, one bit per bit_en strobe.
module gen2_cmd_tx
    import gen2_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  cmd_sel,
    input  logic        dr,
    input  logic        trext,
    input  logic        target,
    input  logic [1:0]  m,
    input  logic [1:0]  sel,
    input  logic [1:0]  session,
    input  logic [3:0]  q,
    input  logic [2:0]  updn,
    input  logic [15:0] rn16,
    input  logic [1:0]  membank,
    input  logic [7:0]  wordptr,
    input  logic [7:0]  wordcount,
    input  logic        bit_en,
    output logic        bitout,
    output logic        bit_valid,
    output logic        preamble,
    output logic        busy,
    output logic        done,
    output logic        cmd_err
);

    tx_state_t   state, state_next;
    crc_kind_t   kind;
    logic [63:0] frame;
    logic [63:0] shreg;
    logic [5:0]  remain;
    logic [3:0]  crc_cnt;
    logic        bit_q, is_query, err_q;
    logic        accept, body_step, crc_step, last_crc;
    logic [4:0]  crc5, crc5_next;
    logic [15:0] crc16, crc16_next;

    assign accept    = (state == S_IDLE) && start && cmd_valid(cmd_sel);
    assign body_step = (state == S_BODY) && bit_en;
    assign crc_step  = ((state == S_CRC5) || (state == S_CRC16)) && bit_en;
    assign last_crc  = ((state == S_CRC5) && (crc_cnt == 4'd4)) ||
                       ((state == S_CRC16) && (crc_cnt == 4'd15));

    gen2_crc_gen u_crc (
        .clk        (clk),
        .reset_n    (reset_n),
        .preset     (accept),
        .enable     (body_step),
        .din        (shreg[63]),
        .crc5       (crc5),
        .crc16      (crc16),
        .crc5_next  (crc5_next),
        .crc16_next (crc16_next)
    );

    always_comb begin
        frame = '0;
        case (cmd_sel)
            CMD_QUERYREP: frame = {2'b00, session, 60'd0};
            CMD_ACK:      frame = {2'b01, rn16, 46'd0};
            CMD_QUERY:    frame = {4'b1000, dr, m, trext, sel, session, target, q, 47'd0};
            CMD_QUERYADJ: frame = {4'b1001, session, updn, 55'd0};
            CMD_NACK:     frame = {8'b11000000, 56'd0};
            CMD_REQRN:    frame = {8'b11000001, rn16, 40'd0};
            CMD_READ:     frame = {8'b11000010, membank, wordptr, wordcount, rn16, 22'd0};
            default:      frame = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_BODY;
            S_BODY: begin
                if (bit_en && remain == 6'd1) begin
                    case (kind)
                        CRC_5:   state_next = S_CRC5;
                        CRC_16:  state_next = S_CRC16;
                        default: state_next = S_FINISH;
                    endcase
                end
            end
            S_CRC5, S_CRC16: if (bit_en && last_crc) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // The next bit is registered one edge ahead so the body-to-CRC handoff uses
    // the CRC value that already includes the last body bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            remain   <= '0;
            crc_cnt  <= '0;
            kind     <= CRC_NONE;
            bit_q    <= 1'b0;
            is_query <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !cmd_valid(cmd_sel);
            if (accept) begin
                shreg    <= frame;
                remain   <= cmd_body_len(cmd_sel);
                kind     <= cmd_crc_kind(cmd_sel);
                is_query <= (cmd_sel == CMD_QUERY);
                crc_cnt  <= '0;
                bit_q    <= frame[63];
            end else if (body_step) begin
                shreg  <= {shreg[62:0], 1'b0};
                remain <= remain - 6'd1;
                if (remain == 6'd1) begin
                    case (kind)
                        CRC_5:   bit_q <= crc5_next[4];
                        CRC_16:  bit_q <= ~crc16_next[15];
                        default: bit_q <= 1'b0;
                    endcase
                end else begin
                    bit_q <= shreg[62];
                end
            end else if (crc_step) begin
                crc_cnt <= crc_cnt + 4'd1;
                if (last_crc)              bit_q <= 1'b0;
                else if (state == S_CRC5)  bit_q <= crc5[3'd3 - crc_cnt[2:0]];
                else                       bit_q <= ~crc16[4'd14 - crc_cnt];
            end
        end
    end

    assign bitout    = bit_q;
    assign busy      = (state == S_BODY) || (state == S_CRC5) || (state == S_CRC16);
    assign bit_valid = busy;
    assign preamble  = is_query && busy;
    assign done      = (state == S_FINISH);
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_gen2_cmd_tx.sv
// Randomized self-checking bench for gen2_cmd_tx against a bit-list frame model
// with generic CRC arithmetic and loopback residue checks.
module tb_gen2_cmd_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        dr = 1'b0, trext = 1'b0, target = 1'b0;
    logic [1:0]  m = 2'd0, sel = 2'd0, session = 2'd0, membank = 2'd0;
    logic [3:0]  q = 4'd0;
    logic [2:0]  updn = 3'd0;
    logic [15:0] rn16 = 16'd0;
    logic [7:0]  wordptr = 8'd0, wordcount = 8'd0;
    logic        bit_en = 1'b0;
    logic        bitout, bit_valid, preamble, busy, done, cmd_err;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_vec, got_vec;
    int          exp_len, got_len;
    logic        exp_pre;
    int          frame_cycles;
    bit          unstable, pre_bad, err_seen, timed_out;
    logic [3:0]  valid_cmds [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};

    gen2_cmd_tx dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd_sel(cmd_sel),
        .dr(dr), .trext(trext), .target(target), .m(m), .sel(sel),
        .session(session), .q(q), .updn(updn), .rn16(rn16),
        .membank(membank), .wordptr(wordptr), .wordcount(wordcount),
        .bit_en(bit_en), .bitout(bitout), .bit_valid(bit_valid),
        .preamble(preamble), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Generic MSB-first CRC over the first n bits of v (v[63] is the first bit).
    function automatic logic [15:0] crc_calc(input logic [63:0] v, input int n, input bit is16);
        logic [15:0] r;
        logic        top;
        r = is16 ? 16'hFFFF : 16'h0009;
        for (int i = 0; i < n; i++) begin
            top = is16 ? r[15] : r[4];
            r = r << 1;
            if (top ^ v[63-i]) r = r ^ (is16 ? 16'h1021 : 16'h0009);
            if (!is16) r[15:5] = '0;
        end
        return r;
    endfunction

    task automatic push_bits(input logic [15:0] val, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            exp_vec[63-exp_len] = val[i];
            exp_len++;
        end
    endtask

    task automatic rand_fields();
        dr = 1'($urandom); trext = 1'($urandom); target = 1'($urandom);
        m = 2'($urandom); sel = 2'($urandom); session = 2'($urandom);
        q = 4'($urandom); updn = 3'($urandom); rn16 = 16'($urandom);
        membank = 2'($urandom); wordptr = 8'($urandom); wordcount = 8'($urandom);
    endtask

    task automatic build_expected(input logic [3:0] cmd);
        logic [15:0] c;
        exp_vec = '0; exp_len = 0; exp_pre = (cmd == 4'd2);
        case (cmd)
            4'd0: begin push_bits(16'b00, 2); push_bits(16'(session), 2); end
            4'd1: begin push_bits(16'b01, 2); push_bits(rn16, 16); end
            4'd2: begin
                push_bits(16'b1000, 4); push_bits(16'(dr), 1); push_bits(16'(m), 2);
                push_bits(16'(trext), 1); push_bits(16'(sel), 2); push_bits(16'(session), 2);
                push_bits(16'(target), 1); push_bits(16'(q), 4);
                c = crc_calc(exp_vec, exp_len, 1'b0);
                push_bits(c, 5);
            end
            4'd3: begin push_bits(16'b1001, 4); push_bits(16'(session), 2); push_bits(16'(updn), 3); end
            4'd5: push_bits(16'b11000000, 8);
            4'd6: begin
                push_bits(16'b11000001, 8); push_bits(rn16, 16);
                c = ~crc_calc(exp_vec, exp_len, 1'b1);
                push_bits(c, 16);
            end
            4'd7: begin
                push_bits(16'b11000010, 8); push_bits(16'(membank), 2);
                push_bits(16'(wordptr), 8); push_bits(16'(wordcount), 8); push_bits(rn16, 16);
                c = ~crc_calc(exp_vec, exp_len, 1'b1);
                push_bits(c, 16);
            end
            default: ;
        endcase
    endtask

    // Issues start at the current negedge, scrambles the field inputs after the
    // accept edge, and collects bits consumed by bit_en until done.
    task automatic send_frame(input int max_gap, input int poke_at, input logic [3:0] poke_cmd,
                              input bit en_with_start);
        int  gap_left, cycles;
        bit  prev_en;
        logic prev_bit;
        start = 1'b1; bit_en = en_with_start;
        @(negedge clk);
        start = 1'b0; bit_en = 1'b0;
        rand_fields(); cmd_sel = 4'($urandom);
        got_vec = '0; got_len = 0;
        unstable = 0; pre_bad = 0; err_seen = 0; timed_out = 0;
        checks++;
        if (bit_valid !== 1'b1 || busy !== 1'b1 || bitout !== exp_vec[63]) begin
            failures++;
            $display("[TB] FAIL accept_latency got valid=%b busy=%b bit=%b want 1 1 %b",
                     bit_valid, busy, bitout, exp_vec[63]);
        end
        gap_left = $urandom_range(0, max_gap);
        prev_en = 1'b1; prev_bit = bitout; cycles = 0;
        while (1) begin
            if (done === 1'b1) break;
            if (cycles >= 500) begin timed_out = 1; break; end
            if (preamble !== exp_pre || bit_valid !== 1'b1) pre_bad = 1;
            if (!prev_en && bitout !== prev_bit) unstable = 1;
            if (cmd_err !== 1'b0) err_seen = 1;
            start = (cycles == poke_at);
            if (cycles == poke_at) cmd_sel = poke_cmd;
            if (gap_left == 0) begin
                bit_en = 1'b1;
                if (got_len < 64) got_vec[63-got_len] = bitout;
                got_len++;
                gap_left = $urandom_range(0, max_gap);
            end else begin
                bit_en = 1'b0;
                gap_left--;
            end
            prev_en = bit_en; prev_bit = bitout;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0; bit_en = 1'b0;
        frame_cycles = cycles;
        checks++;
        if (timed_out) begin
            failures++;
            $display("[TB] FAIL done_timeout got no done after %0d cycles want done", cycles);
        end else begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0 || bitout !== 1'b0) begin
                failures++;
                $display("[TB] FAIL done_pulse got done=%b busy=%b valid=%b bit=%b want 0 0 0 0",
                         done, busy, bit_valid, bitout);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; bit_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bitout, bit_valid, preamble, busy, done, cmd_err} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got %b want 000000",
                     {bitout, bit_valid, preamble, busy, done, cmd_err});
        end
        reset_n = 1'b1;
        @(negedge clk);
        bit_en = 1'b1;
        repeat (3) @(negedge clk);
        bit_en = 1'b0;
        checks++;
        if ({bitout, bit_valid, busy, done} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL idle_bit_en got %b want 0000", {bitout, bit_valid, busy, done});
        end
    endtask

    task automatic test_nack();
        logic [7:0] lit;
        lit = 8'b11000000;
        rand_fields(); cmd_sel = 4'd5; build_expected(4'd5);
        send_frame(0, -1, 4'd0, 1'b0);
        checks++;
        if (got_vec !== exp_vec || got_len != 8 || got_vec[63:56] !== lit) begin
            failures++;
            $display("[TB] FAIL nack_bits got %h/%0d want %h/8", got_vec, got_len, exp_vec);
        end
        checks++;
        if (frame_cycles != 8 || pre_bad) begin
            failures++;
            $display("[TB] FAIL nack_timing got cycles=%0d pre_bad=%0d want 8 0", frame_cycles, pre_bad);
        end
    endtask

    task automatic test_queryrep_ack();
        logic [17:0] ack_lit;
        rand_fields(); session = 2'd2; cmd_sel = 4'd0; build_expected(4'd0);
        send_frame(0, -1, 4'd0, 1'b0);
        checks++;
        if (got_vec !== exp_vec || got_len != 4 || got_vec[63:60] !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL queryrep_bits got %h/%0d want %h/4", got_vec, got_len, exp_vec);
        end
        ack_lit = {2'b01, 16'hA5A5};
        rand_fields(); rn16 = 16'hA5A5; cmd_sel = 4'd1; build_expected(4'd1);
        send_frame(0, -1, 4'd0, 1'b0);
        checks++;
        if (got_vec !== exp_vec || got_len != 18 || got_vec[63:46] !== ack_lit) begin
            failures++;
            $display("[TB] FAIL ack_bits got %h/%0d want %h/18", got_vec, got_len, exp_vec);
        end
    endtask

    task automatic test_query(input int max_gap);
        rand_fields(); dr = 1'b1; m = 2'd2; trext = 1'b1; q = 4'd4;
        cmd_sel = 4'd2; build_expected(4'd2);
        send_frame(max_gap, -1, 4'd0, 1'b0);
        checks++;
        if (got_vec !== exp_vec || got_len != 22) begin
            failures++;
            $display("[TB] FAIL query_bits got %h/%0d want %h/22", got_vec, got_len, exp_vec);
        end
        checks++;
        if (crc_calc(got_vec, 22, 1'b0) !== 16'h0 || got_vec[63:60] !== 4'b1000 ||
            got_vec[59] !== 1'b1 || got_vec[58:57] !== 2'd2 || got_vec[56] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL query_loopback got residue=%h hdr=%b want residue 0 hdr 1000 1 10 1",
                     crc_calc(got_vec, 22, 1'b0), got_vec[63:56]);
        end
        checks++;
        if (pre_bad) begin
            failures++;
            $display("[TB] FAIL query_preamble got dropped want 1 throughout");
        end
    endtask

    task automatic test_crc16(input logic [3:0] cmd, input int len);
        logic [63:0] flipped;
        build_expected(cmd); cmd_sel = cmd;
        send_frame(0, -1, 4'd0, 1'b0);
        checks++;
        if (got_vec !== exp_vec || got_len != len) begin
            failures++;
            $display("[TB] FAIL crc16_bits cmd=%0d got %h/%0d want %h/%0d", cmd, got_vec, got_len, exp_vec, len);
        end
        checks++;
        if (crc_calc(got_vec, len, 1'b1) !== 16'h1D0F) begin
            failures++;
            $display("[TB] FAIL crc16_residue cmd=%0d got %h want 1d0f", cmd, crc_calc(got_vec, len, 1'b1));
        end
        flipped = got_vec;
        flipped[63 - $urandom_range(0, len - 1)] ^= 1'b1;
        checks++;
        if (crc_calc(flipped, len, 1'b1) === 16'h1D0F) begin
            failures++;
            $display("[TB] FAIL crc16_flip cmd=%0d got residue 1d0f want other", cmd);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] c;
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            c = valid_cmds[$urandom_range(0, 6)];
            cmd_sel = c; build_expected(c);
            send_frame(5, -1, 4'd0, 1'b1);
            checks++;
            if (got_vec !== exp_vec || got_len != exp_len || unstable || pre_bad) begin
                failures++;
                $display("[TB] FAIL gap_frame cmd=%0d got %h/%0d unstable=%0d want %h/%0d",
                         c, got_vec, got_len, unstable, exp_vec, exp_len);
            end
        end
    endtask

    task automatic test_cmd_err();
        logic [3:0] bad;
        for (int i = 0; i < 4; i++) begin
            bad = (i == 0) ? 4'd4 : 4'(8 + $urandom_range(0, 7));
            cmd_sel = bad; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cmd_err !== 1'b1 || busy !== 1'b0 || bit_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL cmd_err_pulse sel=%0d got err=%b busy=%b want 1 0", bad, cmd_err, busy);
            end
            @(negedge clk);
            checks++;
            if (cmd_err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL cmd_err_clear sel=%0d got err=%b busy=%b want 0 0", bad, cmd_err, busy);
            end
        end
    endtask

    task automatic test_start_busy();
        rand_fields(); cmd_sel = 4'd7; build_expected(4'd7);
        send_frame(1, 10, 4'd4, 1'b0);
        checks++;
        if (got_vec !== exp_vec || got_len != 58 || err_seen) begin
            failures++;
            $display("[TB] FAIL busy_start_invalid got %h/%0d err=%0d want %h/58 err 0",
                     got_vec, got_len, err_seen, exp_vec);
        end
        rand_fields(); cmd_sel = 4'd5; build_expected(4'd5);
        send_frame(0, 3, 4'd2, 1'b0);
        checks++;
        if (got_vec !== exp_vec || got_len != 8 || pre_bad || err_seen) begin
            failures++;
            $display("[TB] FAIL busy_start_valid got %h/%0d pre_bad=%0d want %h/8",
                     got_vec, got_len, pre_bad, exp_vec);
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        rand_fields(); cmd_sel = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; bit_en = 1'b1;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bitout, bit_valid, preamble, busy, done, cmd_err} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_abort got %b want 000000",
                     {bitout, bit_valid, preamble, busy, done, cmd_err});
        end
        bit_en = 1'b0;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen = 1;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (done !== 1'b0) done_seen = 1;
        checks++;
        if (done_seen) begin
            failures++;
            $display("[TB] FAIL reset_no_done got done=1 want 0");
        end
        test_query(2);
    endtask

    task automatic test_back_to_back();
        logic [3:0] c;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            c = valid_cmds[$urandom_range(0, 6)];
            cmd_sel = c; build_expected(c);
            send_frame(0, -1, 4'd0, 1'b0);
            checks++;
            if (got_vec !== exp_vec || got_len != exp_len || frame_cycles != exp_len) begin
                failures++;
                $display("[TB] FAIL b2b_frame cmd=%0d got %h/%0d cyc=%0d want %h/%0d",
                         c, got_vec, got_len, frame_cycles, exp_vec, exp_len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nack();
        test_queryrep_ack();
        test_query(0);
        rand_fields(); rn16 = 16'h1234;
        test_crc16(4'd6, 40);
        rand_fields(); membank = 2'd3; wordptr = 8'h10; wordcount = 8'd2;
        test_crc16(4'd7, 58);
        test_gaps();
        test_cmd_err();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
